// File: rtl/cc_blk_arb.sv
// Two-channel round-robin arbiter sharing one cc_block keystream core.
// Optional WAIT watchdog enabled by defining CC_ARB_WDOG_EN.
module cc_blk_arb #(
  parameter int unsigned WDOG_MAX = 32
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [1:0]   i_req,
  input  logic [255:0] i_key0,
  input  logic [255:0] i_key1,
  input  logic [95:0]  i_non0,
  input  logic [95:0]  i_non1,
  input  logic [31:0]  i_cnt0,
  input  logic [31:0]  i_cnt1,
  input  logic [1:0]   i_ack,
  output logic [1:0]   o_vld,
  output logic [511:0] o_stream,
  output logic [1:0]   o_gnt,
  output logic [1:0]   o_err,
  output logic         o_blk_start,
  output logic [255:0] o_blk_key,
  output logic [95:0]  o_blk_non,
  output logic [31:0]  o_blk_cnt,
  input  logic [511:0] i_blk_stream,
  input  logic         i_blk_done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DELIV = 2'd3
  } state_e;

  state_e         state_q, state_d;
  logic           rr_q, rr_d;
  logic [1:0]     gnt_q, gnt_d;
  logic [511:0]   stream_q, stream_d;
  logic [255:0]   key_q, key_d;
  logic [95:0]    non_q, non_d;
  logic [31:0]    cnt_q, cnt_d;
  logic           sel;
  logic           owner;

`ifdef CC_ARB_WDOG_EN
  localparam int unsigned WDOG_W = $clog2(WDOG_MAX + 1);
  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic [1:0]        err_q, err_d;
`endif

  // Dual requests are resolved by rr; a lone request wins outright.
  assign sel   = (i_req == 2'b11) ? rr_q : i_req[1];
  assign owner = gnt_q[1];

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    gnt_d    = gnt_q;
    stream_d = stream_q;
    key_d    = key_q;
    non_d    = non_q;
    cnt_d    = cnt_q;
`ifdef CC_ARB_WDOG_EN
    wdog_d   = wdog_q;
    err_d    = 2'b00;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (i_req != 2'b00) begin
          gnt_d   = sel ? 2'b10 : 2'b01;
          key_d   = sel ? i_key1 : i_key0;
          non_d   = sel ? i_non1 : i_non0;
          cnt_d   = sel ? i_cnt1 : i_cnt0;
          state_d = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        state_d = ST_WAIT;
`ifdef CC_ARB_WDOG_EN
        wdog_d  = WDOG_W'(1);
`endif
      end

      ST_WAIT: begin
        // Done takes priority over a watchdog expiry in the same cycle.
        if (i_blk_done) begin
          stream_d = i_blk_stream;
          state_d  = ST_DELIV;
`ifdef CC_ARB_WDOG_EN
        end else if (wdog_q == WDOG_W'(WDOG_MAX)) begin
          err_d   = gnt_q;
          gnt_d   = 2'b00;
          rr_d    = ~owner;
          state_d = ST_IDLE;
        end else begin
          wdog_d  = wdog_q + WDOG_W'(1);
`endif
        end
      end

      ST_DELIV: begin
        if (i_ack[owner]) begin
          gnt_d   = 2'b00;
          rr_d    = ~owner;
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of the others, independent of statement order.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= ST_IDLE;
      rr_q     <= 1'b0;
      gnt_q    <= 2'b00;
      stream_q <= '0;
      key_q    <= '0;
      non_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      gnt_q    <= gnt_d;
      stream_q <= stream_d;
      key_q    <= key_d;
      non_q    <= non_d;
      cnt_q    <= cnt_d;
    end
  end

`ifdef CC_ARB_WDOG_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wdog_q <= '0;
      err_q  <= 2'b00;
    end else begin
      wdog_q <= wdog_d;
      err_q  <= err_d;
    end
  end

  assign o_err = err_q;
`else
  assign o_err = 2'b00;
`endif

  assign o_gnt       = gnt_q;
  assign o_vld       = (state_q == ST_DELIV) ? gnt_q : 2'b00;
  assign o_blk_start = (state_q == ST_ISSUE);
  assign o_stream    = stream_q;
  assign o_blk_key   = key_q;
  assign o_blk_non   = non_q;
  assign o_blk_cnt   = cnt_q;

endmodule

// File: tb/tb_cc_blk_arb.sv
// Directed self-checking bench for cc_blk_arb: table-driven contention run
// plus hand sequences for latency, operand stability, reset and watchdog.
module tb_cc_blk_arb;

  localparam logic [255:0] K0 = {8{32'h1111_0000}};
  localparam logic [255:0] K1 = {8{32'h2222_0001}};
  localparam logic [255:0] KX = {8{32'hDEAD_BEEF}};
  localparam logic [95:0]  N0 = {3{32'h0A0A_0A0A}};
  localparam logic [95:0]  N1 = {3{32'h0B0B_0B0B}};
  localparam logic [31:0]  C0 = 32'h0000_0001;
  localparam logic [31:0]  C1 = 32'h0000_0055;
  localparam logic [511:0] S1 = {16{32'h5100_0001}};
  localparam logic [511:0] S2 = {16{32'h5200_0002}};
  localparam logic [511:0] S3 = {16{32'h5300_0003}};
  localparam logic [511:0] S4 = {16{32'h5400_0004}};
  localparam logic [511:0] S5 = {16{32'h5500_0005}};

  logic         i_clk = 1'b0;
  logic         i_rst;
  logic [1:0]   i_req;
  logic [255:0] i_key0, i_key1;
  logic [95:0]  i_non0, i_non1;
  logic [31:0]  i_cnt0, i_cnt1;
  logic [1:0]   i_ack;
  logic [1:0]   o_vld;
  logic [511:0] o_stream;
  logic [1:0]   o_gnt;
  logic [1:0]   o_err;
  logic         o_blk_start;
  logic [255:0] o_blk_key;
  logic [95:0]  o_blk_non;
  logic [31:0]  o_blk_cnt;
  logic [511:0] i_blk_stream;
  logic         i_blk_done;

  int n_checks = 0;
  int n_errors = 0;

  cc_blk_arb dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_req       (i_req),
    .i_key0      (i_key0),
    .i_key1      (i_key1),
    .i_non0      (i_non0),
    .i_non1      (i_non1),
    .i_cnt0      (i_cnt0),
    .i_cnt1      (i_cnt1),
    .i_ack       (i_ack),
    .o_vld       (o_vld),
    .o_stream    (o_stream),
    .o_gnt       (o_gnt),
    .o_err       (o_err),
    .o_blk_start (o_blk_start),
    .o_blk_key   (o_blk_key),
    .o_blk_non   (o_blk_non),
    .o_blk_cnt   (o_blk_cnt),
    .i_blk_stream(i_blk_stream),
    .i_blk_done  (i_blk_done)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [1:0]   req;
    logic [1:0]   ack;
    logic         done;
    logic [511:0] strm;
    logic [1:0]   gnt;
    logic [1:0]   vld;
    logic         start;
    logic         chk_key;
    logic [255:0] key;
    logic [511:0] stream;
  } vec_t;

  vec_t tbl [19];

  function automatic vec_t mk(input logic [1:0] req, input logic [1:0] ack,
                              input logic done, input logic [511:0] strm,
                              input logic [1:0] gnt, input logic [1:0] vld,
                              input logic start, input logic chk_key,
                              input logic [255:0] key, input logic [511:0] stream);
    vec_t v;
    v.req = req; v.ack = ack; v.done = done; v.strm = strm;
    v.gnt = gnt; v.vld = vld; v.start = start; v.chk_key = chk_key;
    v.key = key; v.stream = stream;
    return v;
  endfunction

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs change right after the sample point; outputs are read #1 past the edge.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    // Rows: inputs applied for one cycle, expected outputs after that edge.
    tbl[0]  = mk(2'b00, 2'b00, 1'b1, S1, 2'b00, 2'b00, 1'b0, 1'b0, '0, '0);
    tbl[1]  = mk(2'b00, 2'b10, 1'b0, '0, 2'b00, 2'b00, 1'b0, 1'b0, '0, '0);
    tbl[2]  = mk(2'b11, 2'b00, 1'b0, '0, 2'b01, 2'b00, 1'b1, 1'b1, K0, '0);
    tbl[3]  = mk(2'b11, 2'b00, 1'b0, '0, 2'b01, 2'b00, 1'b0, 1'b1, K0, '0);
    tbl[4]  = mk(2'b11, 2'b00, 1'b1, S1, 2'b01, 2'b01, 1'b0, 1'b1, K0, S1);
    tbl[5]  = mk(2'b11, 2'b10, 1'b1, S2, 2'b01, 2'b01, 1'b0, 1'b1, K0, S1);
    tbl[6]  = mk(2'b11, 2'b01, 1'b0, '0, 2'b00, 2'b00, 1'b0, 1'b0, '0, S1);
    tbl[7]  = mk(2'b11, 2'b00, 1'b0, '0, 2'b10, 2'b00, 1'b1, 1'b1, K1, S1);
    tbl[8]  = mk(2'b11, 2'b00, 1'b1, S2, 2'b10, 2'b00, 1'b0, 1'b1, K1, S1);
    tbl[9]  = mk(2'b11, 2'b00, 1'b1, S2, 2'b10, 2'b10, 1'b0, 1'b1, K1, S2);
    tbl[10] = mk(2'b11, 2'b10, 1'b0, '0, 2'b00, 2'b00, 1'b0, 1'b0, '0, S2);
    tbl[11] = mk(2'b11, 2'b00, 1'b0, '0, 2'b01, 2'b00, 1'b1, 1'b1, K0, S2);
    tbl[12] = mk(2'b11, 2'b00, 1'b0, '0, 2'b01, 2'b00, 1'b0, 1'b1, K0, S2);
    tbl[13] = mk(2'b11, 2'b00, 1'b1, S3, 2'b01, 2'b01, 1'b0, 1'b1, K0, S3);
    tbl[14] = mk(2'b11, 2'b01, 1'b0, '0, 2'b00, 2'b00, 1'b0, 1'b0, '0, S3);
    tbl[15] = mk(2'b11, 2'b00, 1'b0, '0, 2'b10, 2'b00, 1'b1, 1'b1, K1, S3);
    tbl[16] = mk(2'b11, 2'b00, 1'b0, '0, 2'b10, 2'b00, 1'b0, 1'b1, K1, S3);
    tbl[17] = mk(2'b11, 2'b00, 1'b1, S4, 2'b10, 2'b10, 1'b0, 1'b1, K1, S4);
    tbl[18] = mk(2'b00, 2'b10, 1'b0, '0, 2'b00, 2'b00, 1'b0, 1'b0, '0, S4);

    i_rst = 1'b1; i_req = 2'b00; i_ack = 2'b00;
    i_key0 = K0; i_key1 = K1; i_non0 = N0; i_non1 = N1;
    i_cnt0 = C0; i_cnt1 = C1;
    i_blk_done = 1'b0; i_blk_stream = '0;

    // Reset values
    tick(); tick();
    check("rst gnt",    512'(o_gnt), 512'(2'b00));
    check("rst vld",    512'(o_vld), 512'(2'b00));
    check("rst err",    512'(o_err), 512'(2'b00));
    check("rst start",  512'(o_blk_start), 512'(1'b0));
    check("rst stream", o_stream, '0);
    check("rst key",    512'(o_blk_key), '0);
    check("rst non",    512'(o_blk_non), '0);
    check("rst cnt",    512'(o_blk_cnt), '0);
    i_rst = 1'b0;

    // Single request on channel 0, done ten cycles after start
    i_req = 2'b01;
    tick();
    check("single start T+1", 512'(o_blk_start), 512'(1'b1));
    check("single gnt",       512'(o_gnt), 512'(2'b01));
    check("single cnt",       512'(o_blk_cnt), 512'(C0));
    check("single key",       512'(o_blk_key), 512'(K0));
    check("single non",       512'(o_blk_non), 512'(N0));
    tick();
    check("single start one cycle", 512'(o_blk_start), 512'(1'b0));
    repeat (8) tick();
    check("single wait vld", 512'(o_vld), 512'(2'b00));
    check("single wait gnt", 512'(o_gnt), 512'(2'b01));
    i_blk_stream = S1; i_blk_done = 1'b1;
    tick();
    i_blk_done = 1'b0;
    check("single vld D+1", 512'(o_vld), 512'(2'b01));
    check("single stream",  o_stream, S1);
    repeat (3) tick();
    check("single vld held", 512'(o_vld), 512'(2'b01));
    i_ack = 2'b01; i_req = 2'b00;
    tick();
    i_ack = 2'b00;
    check("single ack vld", 512'(o_vld), 512'(2'b00));
    check("single ack gnt", 512'(o_gnt), 512'(2'b00));

    // Reset while channel 1 waits, then a late done
    i_req = 2'b10;
    tick();
    check("rstwait gnt", 512'(o_gnt), 512'(2'b10));
    check("rstwait cnt", 512'(o_blk_cnt), 512'(C1));
    i_req = 2'b00;
    tick();
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    check("rstwait gnt cleared", 512'(o_gnt), 512'(2'b00));
    check("rstwait key cleared", 512'(o_blk_key), '0);
    check("rstwait stream",      o_stream, '0);
    check("rstwait start",       512'(o_blk_start), 512'(1'b0));
    i_blk_stream = S2; i_blk_done = 1'b1;
    tick();
    i_blk_done = 1'b0;
    check("late done vld",    512'(o_vld), 512'(2'b00));
    check("late done stream", o_stream, '0);
    check("late done err",    512'(o_err), 512'(2'b00));

    // Stray events and continuous dual-request contention (rr back at 0)
    for (int i = 0; i < 19; i++) begin
      i_req = tbl[i].req; i_ack = tbl[i].ack;
      i_blk_done = tbl[i].done; i_blk_stream = tbl[i].strm;
      tick();
      check($sformatf("tbl[%0d] gnt", i),    512'(o_gnt), 512'(tbl[i].gnt));
      check($sformatf("tbl[%0d] vld", i),    512'(o_vld), 512'(tbl[i].vld));
      check($sformatf("tbl[%0d] start", i),  512'(o_blk_start), 512'(tbl[i].start));
      check($sformatf("tbl[%0d] stream", i), o_stream, tbl[i].stream);
      check($sformatf("tbl[%0d] err", i),    512'(o_err), 512'(2'b00));
      if (tbl[i].chk_key)
        check($sformatf("tbl[%0d] key", i), 512'(o_blk_key), 512'(tbl[i].key));
    end
    i_req = 2'b00; i_ack = 2'b00; i_blk_done = 1'b0;

    // Operand stability: key change and request drop during WAIT
    i_req = 2'b01;
    tick();
    check("stab gnt", 512'(o_gnt), 512'(2'b01));
    tick();
    i_key0 = KX; i_req = 2'b00;
    repeat (3) tick();
    check("stab key", 512'(o_blk_key), 512'(K0));
    check("stab non", 512'(o_blk_non), 512'(N0));
    check("stab cnt", 512'(o_blk_cnt), 512'(C0));
    i_blk_stream = S5; i_blk_done = 1'b1;
    tick();
    i_blk_done = 1'b0;
    check("stab vld",    512'(o_vld), 512'(2'b01));
    check("stab stream", o_stream, S5);
    check("stab key dl", 512'(o_blk_key), 512'(K0));
    i_ack = 2'b01;
    tick();
    i_ack = 2'b00; i_key0 = K0;
    check("stab ack vld", 512'(o_vld), 512'(2'b00));

`ifdef CC_ARB_WDOG_EN
    // Watchdog abort after 32 WAIT cycles on channel 1
    i_req = 2'b10;
    tick();
    check("wdog gnt", 512'(o_gnt), 512'(2'b10));
    i_req = 2'b00;
    tick();
    for (int i = 0; i < 31; i++) begin
      tick();
      check($sformatf("wdog pre %0d err", i), 512'(o_err), 512'(2'b00));
      check($sformatf("wdog pre %0d gnt", i), 512'(o_gnt), 512'(2'b10));
    end
    tick();
    check("wdog err pulse", 512'(o_err), 512'(2'b10));
    check("wdog gnt clear", 512'(o_gnt), 512'(2'b00));
    check("wdog vld",       512'(o_vld), 512'(2'b00));
    tick();
    check("wdog err one cycle", 512'(o_err), 512'(2'b00));
    // Done arriving in the 32nd WAIT cycle beats the timeout
    i_req = 2'b01;
    tick();
    check("wdog rr advanced", 512'(o_gnt), 512'(2'b01));
    i_req = 2'b00;
    tick();
    repeat (31) tick();
    i_blk_stream = S3; i_blk_done = 1'b1;
    tick();
    i_blk_done = 1'b0;
    check("wdog tie vld",    512'(o_vld), 512'(2'b01));
    check("wdog tie err",    512'(o_err), 512'(2'b00));
    check("wdog tie stream", o_stream, S3);
    i_ack = 2'b01;
    tick();
    i_ack = 2'b00;
`else
    // Without the watchdog WAIT is unbounded and o_err stays low
    i_req = 2'b10;
    tick();
    check("nowdog gnt", 512'(o_gnt), 512'(2'b10));
    i_req = 2'b00;
    tick();
    for (int i = 0; i < 40; i++) begin
      tick();
      check($sformatf("nowdog %0d err", i), 512'(o_err), 512'(2'b00));
      check($sformatf("nowdog %0d gnt", i), 512'(o_gnt), 512'(2'b10));
    end
    i_blk_stream = S4; i_blk_done = 1'b1;
    tick();
    i_blk_done = 1'b0;
    check("nowdog vld",    512'(o_vld), 512'(2'b10));
    check("nowdog stream", o_stream, S4);
    i_ack = 2'b10;
    tick();
    i_ack = 2'b00;
    check("nowdog ack gnt", 512'(o_gnt), 512'(2'b00));
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
